// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute path: default widths, opcodes,
// NZP bit positions and the issue controller state encoding.
package alu_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_OP_W   = 4;
  localparam int ALU_RD_W   = 4;

  // Wide enough for the largest legal ALU latency (15).
  localparam int CNT_W = 4;

  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;

  localparam int NZP_POS  = 2;
  localparam int NZP_ZERO = 1;
  localparam int NZP_NEG  = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } issue_state_t;

endpackage : alu_pkg

// File: rtl/alu_issue_ctrl.sv
// Single-instruction ALU issue controller: accepts a decoded op, pulses the
// Alu, waits its fixed latency, then returns a writeback or an NZP update.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W      = ALU_DATA_W,
  parameter int OP_W        = ALU_OP_W,
  parameter int RD_W        = ALU_RD_W,
  parameter int ALU_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic              req_compare,
  input  logic [DATA_W-1:0] req_rs,
  input  logic [DATA_W-1:0] req_rt,
  input  logic [RD_W-1:0]   req_rd,

  output logic              alu_execute,
  output logic [OP_W-1:0]   alu_operation,
  output logic              alu_compare,
  output logic [DATA_W-1:0] alu_rs,
  output logic [DATA_W-1:0] alu_rt,
  input  logic [DATA_W-1:0] alu_result,

  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,

  output logic              nzp_valid,
  input  logic              nzp_ready,
  output logic [2:0]        nzp,

  output logic              busy,
  output logic [15:0]       ops_done
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LATENCY);

  issue_state_t      state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              cmp_q, cmp_d;
  logic [DATA_W-1:0] rs_q, rs_d;
  logic [DATA_W-1:0] rt_q, rt_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [15:0]       ops_done_q, ops_done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      cmp_q      <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cmp_q      <= cmp_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      ops_done_q <= ops_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cmp_d         = cmp_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    rd_d          = rd_q;
    cnt_d         = cnt_q;
    res_d         = res_q;
    ops_done_d    = ops_done_q;

    req_ready     = 1'b0;
    alu_execute   = 1'b0;
    alu_operation = '0;
    alu_compare   = 1'b0;
    alu_rs        = '0;
    alu_rt        = '0;
    wb_valid      = 1'b0;
    wb_rd         = '0;
    wb_data       = '0;
    nzp_valid     = 1'b0;
    nzp           = 3'b000;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          cmp_d   = req_compare;
          rs_d    = req_rs;
          rt_d    = req_rt;
          rd_d    = req_rd;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        alu_execute   = 1'b1;
        alu_operation = op_q;
        alu_compare   = cmp_q;
        alu_rs        = rs_q;
        alu_rt        = rt_q;
        cnt_d         = LAT_LOAD;
        state_d       = S_WAIT;
      end

      S_WAIT: begin
        // Operands stay presented so an Alu that samples late still sees them.
        alu_operation = op_q;
        alu_compare   = cmp_q;
        alu_rs        = rs_q;
        alu_rt        = rt_q;
        if (cnt_q == CNT_W'(1)) begin
          res_d   = alu_result;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESP: begin
        if (!cmp_q) begin
          wb_valid = 1'b1;
          wb_rd    = rd_q;
          wb_data  = res_q;
          if (wb_ready) begin
            ops_done_d = ops_done_q + 16'd1;
            state_d    = S_IDLE;
          end
        end else begin
          nzp_valid      = 1'b1;
          nzp[NZP_POS]   = res_q[NZP_POS];
          nzp[NZP_ZERO]  = res_q[NZP_ZERO];
          nzp[NZP_NEG]   = res_q[NZP_NEG];
          if (nzp_ready) begin
            ops_done_d = ops_done_q + 16'd1;
            state_d    = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign ops_done = ops_done_q;

endmodule : alu_issue_ctrl

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl driving a behavioural Alu; expected values come from
// plain arithmetic on the requested operands.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DW  = 8;
  localparam int OW  = 4;
  localparam int RW  = 4;
  localparam int LAT = 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_compare;
  logic [OW-1:0] req_op;
  logic [DW-1:0] req_rs, req_rt;
  logic [RW-1:0] req_rd;
  logic          alu_execute, alu_compare;
  logic [OW-1:0] alu_operation;
  logic [DW-1:0] alu_rs, alu_rt, alu_result;
  logic          wb_valid, wb_ready;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          nzp_valid, nzp_ready;
  logic [2:0]    nzp;
  logic          busy;
  logic [15:0]   ops_done;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  alu_issue_ctrl #(.DATA_W(DW), .OP_W(OW), .RD_W(RW), .ALU_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_compare(req_compare), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .alu_execute(alu_execute), .alu_operation(alu_operation),
    .alu_compare(alu_compare), .alu_rs(alu_rs), .alu_rt(alu_rt),
    .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .nzp_valid(nzp_valid), .nzp_ready(nzp_ready), .nzp(nzp),
    .busy(busy), .ops_done(ops_done)
  );

  // Reference ALU semantics: 4 add, 5 mul, 6 sub, 7 div, compare -> {gt,eq,lt}.
  function automatic logic [DW-1:0] ref_alu(input logic [OW-1:0] op, input logic cmp,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (cmp) return {5'b0, (a > b), (a == b), (a < b)};
    case (op)
      4'd4: return DW'(a + b);
      4'd5: return DW'(a * b);
      4'd6: return DW'(a - b);
      4'd7: return (b == 0) ? '0 : DW'(a / b);
      default: return a;
    endcase
  endfunction

  // Behavioural Alu: result appears LAT edges after the edge sampling execute.
  logic [DW-1:0] alu_pipe [LAT];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) alu_pipe[i] <= '0;
    end else begin
      alu_pipe[0] <= alu_execute ? ref_alu(alu_operation, alu_compare, alu_rs, alu_rt)
                                 : alu_pipe[0];
      for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
  end
  assign alu_result = alu_pipe[LAT-1];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got cyc=%0d required finish", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one instruction and return just after the accepting edge.
  task automatic issue(input logic [OW-1:0] op, input logic cmp, input logic [DW-1:0] rs,
                       input logic [DW-1:0] rt, input logic [RW-1:0] rd);
    int n;
    n = 0;
    req_op = op; req_compare = cmp; req_rs = rs; req_rt = rt; req_rd = rd;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin step(); n++; end
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL accept: req_ready=%b required 1", req_ready);
    else n_pass++;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_compare = 1'b0;
    req_rs = '0; req_rt = '0; req_rd = '0; wb_ready = 1'b0; nzp_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b required 1", req_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
    n_total++; if ({wb_valid, nzp_valid, alu_execute} !== 3'b000)
      $display("FAIL reset_valids: got %b required 000", {wb_valid, nzp_valid, alu_execute}); else n_pass++;
    n_total++; if (ops_done !== 16'd0) $display("FAIL reset_ops_done: got %0d required 0", ops_done); else n_pass++;
    n_total++; if ({alu_rs, alu_rt, wb_data, nzp} !== '0)
      $display("FAIL reset_data_outs: got %h required 0", {alu_rs, alu_rt, wb_data, nzp}); else n_pass++;
    $display("txn reset: req_ready=%b busy=%b ops_done=%0d", req_ready, busy, ops_done);
  endtask

  task automatic test_compare(input logic [DW-1:0] rs, input logic [DW-1:0] rt, input logic [2:0] exp_nzp);
    int n;
    logic [15:0] start;
    start = ops_done; wb_ready = 1'b1; nzp_ready = 1'b1;
    issue(4'd0, 1'b1, rs, rt, 4'd9);
    n = 0;
    while (!(wb_valid || nzp_valid) && n < 30) begin step(); n++; end
    n_total++; if (n !== LAT + 1) $display("FAIL cmp_latency: got %0d required %0d", n, LAT + 1); else n_pass++;
    n_total++; if ({nzp_valid, wb_valid} !== 2'b10)
      $display("FAIL cmp_valids: got nzp_valid/wb_valid=%b required 10", {nzp_valid, wb_valid}); else n_pass++;
    n_total++; if (nzp !== exp_nzp) $display("FAIL cmp_nzp: rs=%0d rt=%0d got %b required %b", rs, rt, nzp, exp_nzp); else n_pass++;
    step();
    n_total++; if (ops_done !== 16'(start + 16'd1))
      $display("FAIL cmp_ops_done: got %0d required %0d", ops_done, start + 16'd1); else n_pass++;
    $display("txn compare rs=%0d rt=%0d nzp=%b ops_done=%0d", rs, rt, exp_nzp, ops_done);
  endtask

  task automatic test_add();
    int n, ex;
    logic [15:0] start;
    start = ops_done; wb_ready = 1'b1; nzp_ready = 1'b1;
    issue(OP_ADD, 1'b0, 8'd255, 8'd2, 4'd7);
    n = 0; ex = 0;
    while (!(wb_valid || nzp_valid) && n < 30) begin
      if (alu_execute) begin
        ex++;
        n_total++; if ({alu_operation, alu_compare, alu_rs, alu_rt} !== {OP_ADD, 1'b0, 8'd255, 8'd2})
          $display("FAIL add_operands: got op=%0d cmp=%b rs=%0d rt=%0d required 4 0 255 2",
                   alu_operation, alu_compare, alu_rs, alu_rt); else n_pass++;
      end
      step(); n++;
    end
    n_total++; if (ex !== 1) $display("FAIL add_exec_pulse: got %0d cycles required 1", ex); else n_pass++;
    n_total++; if (n !== LAT + 1) $display("FAIL add_latency: got %0d required %0d", n, LAT + 1); else n_pass++;
    n_total++; if ({wb_valid, nzp_valid, wb_rd, wb_data} !== {1'b1, 1'b0, 4'd7, 8'h01})
      $display("FAIL add_wb: got v=%b nv=%b rd=%0d data=%h required 1 0 7 01", wb_valid, nzp_valid, wb_rd, wb_data); else n_pass++;
    n_total++; if ({alu_rs, alu_rt} !== '0) $display("FAIL add_operands_idle: got %h required 0", {alu_rs, alu_rt}); else n_pass++;
    step();
    n_total++; if (ops_done !== 16'(start + 16'd1))
      $display("FAIL add_ops_done: got %0d required %0d", ops_done, start + 16'd1); else n_pass++;
    $display("txn add 255+2 rd=7 data=01 ops_done=%0d", ops_done);
  endtask

  task automatic test_mul_backpressure();
    int n;
    logic [15:0] start;
    start = ops_done; wb_ready = 1'b0; nzp_ready = 1'b1;
    issue(OP_MUL, 1'b0, 8'd10, 8'd3, 4'd2);
    n = 0;
    while (!wb_valid && n < 30) begin step(); n++; end
    for (int i = 0; i < 6; i++) begin
      n_total++; if ({wb_valid, wb_rd, wb_data, req_ready, busy} !== {1'b1, 4'd2, 8'h1E, 1'b0, 1'b1})
        $display("FAIL mul_hold[%0d]: got v=%b rd=%0d data=%h rr=%b busy=%b required 1 2 1e 0 1",
                 i, wb_valid, wb_rd, wb_data, req_ready, busy); else n_pass++;
      if (i == 5) wb_ready = 1'b1;
      step();
    end
    n_total++; if ({busy, req_ready, wb_valid} !== 3'b010)
      $display("FAIL mul_idle: got busy/rr/wbv=%b required 010", {busy, req_ready, wb_valid}); else n_pass++;
    n_total++; if (ops_done !== 16'(start + 16'd1))
      $display("FAIL mul_ops_done: got %0d required %0d", ops_done, start + 16'd1); else n_pass++;
    $display("txn mul 10*3 rd=2 data=1e held 6 cycles ops_done=%0d", ops_done);
  endtask

  task automatic test_wrong_ready();
    int n;
    logic [15:0] start;
    start = ops_done; wb_ready = 1'b1; nzp_ready = 1'b0;
    issue(4'd0, 1'b1, 8'd7, 8'd9, 4'd1);
    n = 0;
    while (!nzp_valid && n < 30) begin step(); n++; end
    for (int i = 0; i < 3; i++) begin
      n_total++; if ({nzp_valid, wb_valid, nzp, busy} !== {1'b1, 1'b0, 3'b001, 1'b1})
        $display("FAIL wrong_ready_hold[%0d]: got nv=%b wv=%b nzp=%b busy=%b required 1 0 001 1",
                 i, nzp_valid, wb_valid, nzp, busy); else n_pass++;
      step();
    end
    nzp_ready = 1'b1;
    step();
    n_total++; if ({busy, ops_done} !== {1'b0, 16'(start + 16'd1)})
      $display("FAIL wrong_ready_done: got busy=%b ops=%0d required 0 %0d", busy, ops_done, start + 16'd1); else n_pass++;
    $display("txn compare with wb_ready only, then nzp_ready ops_done=%0d", ops_done);
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    logic [DW-1:0] exp_data[$];
    logic [RW-1:0] exp_rd[$];
    int accepts, resps, n;
    logic took;
    logic [15:0] start;
    start = ops_done; wb_ready = 1'b1; nzp_ready = 1'b1;
    accepts = 0; resps = 0; n = 0;
    req_op = 4'($urandom_range(4, 7)); req_compare = 1'b0;
    req_rs = DW'($urandom); req_rt = DW'($urandom); req_rd = RW'($urandom);
    req_valid = 1'b1;
    while ((accepts < 4 || resps < 4) && n < 60) begin
      took = req_valid && req_ready;
      if (took) begin
        acc_cyc.push_back(cyc);
        exp_data.push_back(ref_alu(req_op, 1'b0, req_rs, req_rt));
        exp_rd.push_back(req_rd);
        accepts++;
      end
      if (wb_valid && wb_ready) begin
        resps++;
        n_total++;
        if (exp_data.size() == 0) $display("FAIL b2b_unexpected_wb: got data=%h required none", wb_data);
        else if ({wb_rd, wb_data} !== {exp_rd[0], exp_data[0]})
          $display("FAIL b2b_wb: got rd=%0d data=%h required rd=%0d data=%h", wb_rd, wb_data, exp_rd[0], exp_data[0]);
        else n_pass++;
        if (exp_data.size() != 0) begin
          $display("txn b2b wb rd=%0d data=%h", wb_rd, wb_data);
          void'(exp_data.pop_front()); void'(exp_rd.pop_front());
        end
      end
      step(); n++;
      if (took) begin
        if (accepts < 4) begin
          req_op = 4'($urandom_range(4, 7));
          req_rs = DW'($urandom); req_rt = DW'($urandom); req_rd = RW'($urandom);
        end else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    n_total++; if ({accepts, resps} !== {32'd4, 32'd4})
      $display("FAIL b2b_count: got accepts=%0d resps=%0d required 4 4", accepts, resps); else n_pass++;
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_total++; if (acc_cyc[i] - acc_cyc[i-1] !== LAT + 3)
        $display("FAIL b2b_spacing[%0d]: got %0d required %0d", i, acc_cyc[i] - acc_cyc[i-1], LAT + 3); else n_pass++;
    end
    n_total++; if (ops_done !== 16'(start + 16'd4))
      $display("FAIL b2b_ops_done: got %0d required %0d", ops_done, start + 16'd4); else n_pass++;
  endtask

  task automatic test_random();
    logic [OW-1:0] op;
    logic cmp, done;
    logic [DW-1:0] rs, rt, exp;
    logic [RW-1:0] rd;
    logic [15:0] start;
    int n;
    for (int k = 0; k < 20; k++) begin
      op = 4'($urandom_range(4, 7)); cmp = 1'($urandom_range(0, 1));
      rs = DW'($urandom); rt = DW'($urandom); rd = RW'($urandom);
      if (k % 5 == 0) rt = rs;
      exp = ref_alu(op, cmp, rs, rt);
      start = ops_done;
      issue(op, cmp, rs, rt, rd);
      n = 0; done = 1'b0;
      while (!done && n < 60) begin
        wb_ready = 1'($urandom_range(0, 1)); nzp_ready = 1'($urandom_range(0, 1));
        if ((wb_valid && wb_ready) || (nzp_valid && nzp_ready)) begin
          n_total++;
          if (cmp && {nzp_valid, wb_valid, nzp} !== {1'b1, 1'b0, exp[2:0]})
            $display("FAIL rand_nzp[%0d]: got nv=%b wv=%b nzp=%b required 1 0 %b", k, nzp_valid, wb_valid, nzp, exp[2:0]);
          else if (!cmp && {wb_valid, nzp_valid, wb_rd, wb_data} !== {1'b1, 1'b0, rd, exp})
            $display("FAIL rand_wb[%0d]: got wv=%b nv=%b rd=%0d data=%h required 1 0 %0d %h",
                     k, wb_valid, nzp_valid, wb_rd, wb_data, rd, exp);
          else n_pass++;
          done = 1'b1;
        end
        step(); n++;
      end
      n_total++; if (!done || busy !== 1'b0 || ops_done !== 16'(start + 16'd1))
        $display("FAIL rand_complete[%0d]: got done=%b busy=%b ops=%0d required 1 0 %0d", k, done, busy, ops_done, start + 16'd1);
      else n_pass++;
      $display("txn rand op=%0d cmp=%b rs=%0d rt=%0d rd=%0d exp=%h", op, cmp, rs, rt, rd, exp);
    end
    wb_ready = 1'b1; nzp_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic seen;
    wb_ready = 1'b1; nzp_ready = 1'b1;
    issue(OP_MUL, 1'b0, 8'd10, 8'd3, 4'd2);
    step();
    n_total++; if ({busy, req_ready} !== 2'b10) $display("FAIL mid_busy: got %b required 10", {busy, req_ready}); else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_total++; if ({req_ready, busy, wb_valid} !== 3'b100)
      $display("FAIL mid_reset_idle: got rr/busy/wbv=%b required 100", {req_ready, busy, wb_valid}); else n_pass++;
    n_total++; if (ops_done !== 16'd0) $display("FAIL mid_reset_ops_done: got %0d required 0", ops_done); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (wb_valid || nzp_valid) seen = 1'b1;
      step();
    end
    n_total++; if (seen !== 1'b0) $display("FAIL mid_reset_no_resp: got response=%b required 0", seen); else n_pass++;
    $display("txn reset during wait: req_ready=%b ops_done=%0d", req_ready, ops_done);
  endtask

  initial begin
    test_reset();
    test_compare(8'd10, 8'd3, 3'b100);
    test_compare(8'd3, 8'd10, 3'b001);
    test_compare(8'd5, 8'd5, 3'b010);
    test_add();
    test_mul_backpressure();
    test_wrong_ready();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_alu_issue_ctrl
